// File: rtl/ahb_accel_banks_pkg.sv
// accel_banks_pkg: shared types, CSR map and byte-enable helper for ahb_accel_banks
package accel_banks_pkg;
    typedef enum logic [1:0] {MODE_COPY, MODE_ADD, MODE_MAX, MODE_RSVD} mode_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam logic [7:0] CSR_CTRL   = 8'h00;
    localparam logic [7:0] CSR_BANKS  = 8'h04;
    localparam logic [7:0] CSR_LEN    = 8'h08;
    localparam logic [7:0] CSR_SCALAR = 8'h0C;
    localparam logic [7:0] CSR_STATUS = 8'h10;
    localparam logic [7:0] CSR_RESULT = 8'h14;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
        return size == 3'd0 ? 4'b0001 << addr : size == 3'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_accel_banks_if.sv
// ahb_accel_banks_if: AHB-Lite slave bus bundle for ahb_accel_banks
interface ahb_accel_banks_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    modport master (output hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
                    input hrdata, hreadyout, hresp);
    modport slave (input hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
                   output hrdata, hreadyout, hresp);
endinterface

// File: rtl/ahb_accel_banks_ram.sv
// accel_bank_ram: one scratch bank; port A byte-write (AHB), port B word-write (engine), 1-cycle reads
module accel_bank_ram #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic [AW-1:0] a_raddr_i,
    input  logic [AW-1:0] a_waddr_i,
    input  logic [3:0]    a_be_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    input  logic [AW-1:0] b_raddr_i,
    input  logic [AW-1:0] b_waddr_i,
    input  logic          b_we_i,
    input  logic [31:0]   b_wdata_i,
    output logic [31:0]   b_rdata_o
);
    logic [31:0] mem_q [2**AW];
    // Each port reads and writes independent words in one cycle (AHB data-phase write, engine write-behind)
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) if (a_be_i[i]) mem_q[a_waddr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        if (b_we_i) mem_q[b_waddr_i] <= b_wdata_i;
        a_rdata_o <= mem_q[a_raddr_i];
        b_rdata_o <= mem_q[b_raddr_i];
    end
endmodule

// File: rtl/ahb_accel_banks.sv
// ahb_accel_banks: AHB-Lite slave over NUM_BANKS scratch banks, CSRs and a COPY/ADD/MAX engine.
// Define ACCEL_IRQ_EN to enable the done interrupt and CTRL.irq_en.
module ahb_accel_banks import accel_banks_pkg::*; #(
    parameter int NUM_BANKS = 2,
    parameter int ADDRWIDTH = 16
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_accel_banks_if.slave bus,
    output logic             irq
);
    localparam int WAW = ADDRWIDTH - 2;
    localparam int WORDS = 2 ** WAW;
    logic acc, a_csr, a_err, busy, ahb_wr, csr_wr, cfg_wr, start_wr, bad, irq_en;
    logic [2:0] a_bank;
    logic dv_q, dw_q, dcsr_q, hreadyout_q;
    logic [2:0] dbank_q;
    logic [ADDRWIDTH-1:0] daddr_q;
    logic [3:0] dbe_q, fwd_be_q;
    logic [1:0] hresp_q;
    logic [31:0] fwd_data_q, bank_rd, src_rd, csr_rd, fwd_mask, b_wdata;
    logic [31:0] a_rdata [NUM_BANKS];
    logic [31:0] b_rdata [NUM_BANKS];
    logic [7:0] off;
    state_e state_q;
    mode_e mode_q;
    logic [2:0] src_q, dst_q;
    logic [ADDRWIDTH-2:0] len_q;
    logic [31:0] scalar_q, result_q;
    logic done_q, err_q, wv_q;
    logic [WAW-1:0] idx_q, widx_q;
    logic unused_bits;
    assign unused_bits = ^{bus.haddr[31:ADDRWIDTH+4], bus.htrans[0]};
    assign acc = bus.hsel & bus.htrans[1] & bus.hready;
    assign a_bank = bus.haddr[ADDRWIDTH+2:ADDRWIDTH];
    assign a_csr = bus.haddr[ADDRWIDTH+3];
    assign busy = state_q != IDLE;
    assign a_err = bus.hsize > 3'd2 || (a_csr ? bus.hsize != 3'd2 || bus.haddr[1:0] != 2'b00
                 : 32'(a_bank) >= NUM_BANKS || (bus.hwrite && busy && a_bank == dst_q));
    assign ahb_wr = dv_q & dw_q;
    assign csr_wr = ahb_wr & dcsr_q;
    assign cfg_wr = csr_wr & ~busy;
    assign off = daddr_q[7:0];
    assign start_wr = csr_wr && off == CSR_CTRL && bus.hwdata[0] && !busy;
    assign bad = 32'(src_q) >= NUM_BANKS || 32'(dst_q) >= NUM_BANKS || bus.hwdata[3:2] == 2'd3
               || 32'(len_q) > WORDS;
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) begin
            dv_q <= 1'b0;
            dw_q <= 1'b0;
            dcsr_q <= 1'b0;
            dbank_q <= '0;
            daddr_q <= '0;
            dbe_q <= '0;
            hreadyout_q <= 1'b1;
            hresp_q <= HRESP_OKAY;
            fwd_be_q <= '0;
            fwd_data_q <= '0;
        end else begin
            dv_q <= acc && !a_err;
            if (acc) begin
                dw_q <= bus.hwrite;
                dcsr_q <= a_csr;
                dbank_q <= a_bank;
                daddr_q <= bus.haddr[ADDRWIDTH-1:0];
                dbe_q <= byte_en(bus.hsize, bus.haddr[1:0]);
            end
            hreadyout_q <= !(acc && a_err);
            hresp_q <= (acc && a_err) || !hreadyout_q ? HRESP_ERROR : HRESP_OKAY;
            // RAM returns pre-write data for a word written this cycle; patch those lanes next cycle
            fwd_be_q <= ahb_wr && !dcsr_q && acc && !a_csr && a_bank == dbank_q
                        && bus.haddr[ADDRWIDTH-1:2] == daddr_q[ADDRWIDTH-1:2] ? dbe_q : 4'h0;
            fwd_data_q <= bus.hwdata;
        end
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) begin
            state_q <= IDLE;
            mode_q <= MODE_COPY;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            scalar_q <= '0;
            result_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            wv_q <= 1'b0;
            idx_q <= '0;
            widx_q <= '0;
        end else begin
            if (cfg_wr && off == CSR_CTRL) mode_q <= mode_e'(bus.hwdata[3:2]);
            if (cfg_wr && off == CSR_BANKS) begin
                src_q <= bus.hwdata[2:0];
                dst_q <= bus.hwdata[10:8];
            end
            if (cfg_wr && off == CSR_LEN) len_q <= bus.hwdata[ADDRWIDTH-2:0];
            if (cfg_wr && off == CSR_SCALAR) scalar_q <= bus.hwdata;
            if (csr_wr && off == CSR_STATUS && bus.hwdata[1]) done_q <= 1'b0;
            if (csr_wr && off == CSR_STATUS && bus.hwdata[2]) err_q <= 1'b0;
            wv_q <= state_q == RUN;
            widx_q <= idx_q;
            if (wv_q && mode_q == MODE_MAX && $signed(src_rd) > $signed(result_q)) result_q <= src_rd;
            if (start_wr) begin
                if (bad) err_q <= 1'b1;
                else if (len_q == '0) done_q <= 1'b1;
                else begin
                    state_q <= RUN;
                    idx_q <= '0;
                    if (bus.hwdata[3:2] == 2'd2) result_q <= 32'h8000_0000;
                end
            end else if (state_q == RUN) begin
                idx_q <= idx_q + WAW'(1);
                if (32'(idx_q) + 1 == 32'(len_q)) state_q <= DRAIN;
            end else if (state_q == DRAIN) begin
                state_q <= IDLE;
                done_q <= 1'b1;
            end
        end
`ifdef ACCEL_IRQ_EN
    logic irq_en_q, irq_q;
    always_ff @(posedge hclk or posedge hreset)
        if (hreset) begin
            irq_en_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (csr_wr && off == CSR_CTRL) irq_en_q <= bus.hwdata[1];
            irq_q <= done_q & irq_en_q;
        end
    assign irq_en = irq_en_q;
    assign irq = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq = 1'b0;
`endif
    always_comb begin
        bank_rd = '0;
        src_rd = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (32'(dbank_q) == i) bank_rd = a_rdata[i];
            if (32'(src_q) == i) src_rd = b_rdata[i];
        end
    end
    assign fwd_mask = {{8{fwd_be_q[3]}}, {8{fwd_be_q[2]}}, {8{fwd_be_q[1]}}, {8{fwd_be_q[0]}}};
    assign csr_rd = off == CSR_CTRL ? {28'h0, mode_q, irq_en, 1'b0}
                  : off == CSR_BANKS ? {21'h0, dst_q, 5'h0, src_q}
                  : off == CSR_LEN ? 32'(len_q)
                  : off == CSR_SCALAR ? scalar_q
                  : off == CSR_STATUS ? {29'h0, err_q, done_q, busy}
                  : off == CSR_RESULT ? result_q : 32'h0;
    assign bus.hrdata = dv_q && !dw_q ? (dcsr_q ? csr_rd : (fwd_data_q & fwd_mask) | (bank_rd & ~fwd_mask)) : 32'h0;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp = hresp_q;
    assign b_wdata = mode_q == MODE_ADD ? src_rd + scalar_q : src_rd;
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        accel_bank_ram #(.AW(WAW)) u_ram (
            .clk_i(hclk),
            .a_raddr_i(bus.haddr[ADDRWIDTH-1:2]),
            .a_waddr_i(daddr_q[ADDRWIDTH-1:2]),
            .a_be_i(ahb_wr && !dcsr_q && 32'(dbank_q) == i ? dbe_q : 4'h0),
            .a_wdata_i(bus.hwdata),
            .a_rdata_o(a_rdata[i]),
            .b_raddr_i(idx_q),
            .b_waddr_i(widx_q),
            .b_we_i(wv_q && mode_q != MODE_MAX && 32'(dst_q) == i),
            .b_wdata_i(b_wdata),
            .b_rdata_o(b_rdata[i])
        );
    end
endmodule
